// File: rtl/zif_cap_ctrl.sv
`timescale 1ns/1ps
// ZIF capture controller: skips SKIP beats, captures CAP_LEN beats through a one-entry
// output register with FRAME_LEN tlast framing, drains, then signals done. Optional test-pattern source: ZIF_CAP_TEST_PATTERN_EN.
module zif_cap_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic        axis_clk,
  input  logic        rst_n,
  input  logic        cfg_wr_in,
  input  logic [1:0]  cfg_addr_in,
  input  logic [31:0] cfg_wdata_in,
  output logic [31:0] sts_out,
  input  logic        axis_rx_tvalid_in,
  input  logic [31:0] axis_rx_tdata_in,
  output logic        axis_tx_tvalid_out,
  output logic [31:0] axis_tx_tdata_out,
  output logic        axis_tx_tlast_out,
  input  logic        axis_tx_tready_in,
  output logic        done_intr_out
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SKIP    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [CNT_W-1:0] cap_len_reg, frame_len_reg, skip_reg;
  logic [CNT_W-1:0] cap_len_act, frame_len_act;
  logic [CNT_W-1:0] skip_cnt, cap_cnt, frame_cnt;
  logic             overflow, done, done_intr;
  logic             tx_valid, tx_last;
  logic [31:0]      tx_data;

  logic             ctrl_wr, abort_req, start_req, slot_free, beat_accept;
  logic             frame_end, cap_end;
  logic [CNT_W-1:0] cap_cnt_nxt, frame_cnt_nxt;
  logic [31:0]      cap_data;
  logic [CNT_W+15:0] cnt_wide;
  logic [15:0]      cnt_field;
  logic             unused_wdata;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    ctrl_wr     = cfg_wr_in && (cfg_addr_in == 2'd0);
    abort_req   = ctrl_wr && cfg_wdata_in[1];
    start_req   = ctrl_wr && cfg_wdata_in[0] && !cfg_wdata_in[1] &&
                  ((state == ST_IDLE) || (state == ST_DONE));
    slot_free   = !tx_valid || axis_tx_tready_in;
    beat_accept = (state == ST_CAPTURE) && axis_rx_tvalid_in && slot_free && !abort_req;
    cap_cnt_nxt   = (cap_cnt == '1)   ? cap_cnt   : cap_cnt + CNT_ONE;
    frame_cnt_nxt = (frame_cnt == '1) ? frame_cnt : frame_cnt + CNT_ONE;
    frame_end   = (frame_len_act != '0) && (frame_cnt_nxt == frame_len_act);
    cap_end     = (cap_cnt_nxt == cap_len_act);
  end

  // The status field is 16 bits wide whatever CNT_W is, so wider counts clamp.
  assign cnt_wide  = {16'd0, cap_cnt};
  assign cnt_field = (cnt_wide > {{CNT_W{1'b0}}, 16'hFFFF}) ? 16'hFFFF : cnt_wide[15:0];
  assign sts_out   = {cnt_field, 11'd0, done, overflow, state};

  assign unused_wdata = ^cfg_wdata_in;

`ifdef ZIF_CAP_TEST_PATTERN_EN
  logic        pat_en;
  logic [31:0] pat_cnt;

  always_ff @(posedge axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_en  <= 1'b0;
      pat_cnt <= 32'd0;
    end else if (start_req) begin
      pat_en  <= cfg_wdata_in[2];
      pat_cnt <= 32'd0;
    end else if (beat_accept) begin
      pat_cnt <= pat_cnt + 32'd1;
    end
  end

  assign cap_data = pat_en ? pat_cnt : axis_rx_tdata_in;
`else
  assign cap_data = axis_rx_tdata_in;
`endif

  // NOTE: sequential state uses non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cap_len_reg   <= '0;
      frame_len_reg <= '0;
      skip_reg      <= '0;
      cap_len_act   <= '0;
      frame_len_act <= '0;
      skip_cnt      <= '0;
      cap_cnt       <= '0;
      frame_cnt     <= '0;
      overflow      <= 1'b0;
      done          <= 1'b0;
      done_intr     <= 1'b0;
      tx_valid      <= 1'b0;
      tx_last       <= 1'b0;
      tx_data       <= 32'd0;
    end else begin
      done_intr <= 1'b0;
      if (tx_valid && axis_tx_tready_in) tx_valid <= 1'b0;

      // Length registers are shadowed; the active copies only change at start.
      if (cfg_wr_in) begin
        case (cfg_addr_in)
          2'd1:    cap_len_reg   <= cfg_wdata_in[CNT_W-1:0];
          2'd2:    frame_len_reg <= cfg_wdata_in[CNT_W-1:0];
          2'd3:    skip_reg      <= cfg_wdata_in[CNT_W-1:0];
          default: ;
        endcase
      end

      if (abort_req) begin
        state    <= ST_IDLE;
        tx_valid <= 1'b0;
        tx_last  <= 1'b0;
      end else if (start_req) begin
        overflow      <= 1'b0;
        done          <= 1'b0;
        cap_cnt       <= '0;
        frame_cnt     <= '0;
        cap_len_act   <= cap_len_reg;
        frame_len_act <= frame_len_reg;
        skip_cnt      <= skip_reg;
        if (skip_reg != '0) begin
          state <= ST_SKIP;
        end else if (cap_len_reg == '0) begin
          state     <= ST_DONE;
          done      <= 1'b1;
          done_intr <= 1'b1;
        end else begin
          state <= ST_CAPTURE;
        end
      end else begin
        case (state)
          ST_SKIP: begin
            if (axis_rx_tvalid_in) begin
              skip_cnt <= skip_cnt - CNT_ONE;
              if (skip_cnt == CNT_ONE) begin
                if (cap_len_act == '0) begin
                  state     <= ST_DONE;
                  done      <= 1'b1;
                  done_intr <= 1'b1;
                end else begin
                  state <= ST_CAPTURE;
                end
              end
            end
          end
          ST_CAPTURE: begin
            if (beat_accept) begin
              tx_valid  <= 1'b1;
              tx_data   <= cap_data;
              tx_last   <= frame_end || cap_end;
              cap_cnt   <= cap_cnt_nxt;
              frame_cnt <= frame_end ? '0 : frame_cnt_nxt;
              if (cap_end) state <= ST_DRAIN;
            end else if (axis_rx_tvalid_in) begin
              overflow <= 1'b1;
            end
          end
          ST_DRAIN: begin
            if (!tx_valid) begin
              state     <= ST_DONE;
              done      <= 1'b1;
              done_intr <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign axis_tx_tvalid_out = tx_valid;
  assign axis_tx_tdata_out  = tx_data;
  assign axis_tx_tlast_out  = tx_last;
  assign done_intr_out      = done_intr;

endmodule

// File: tb/tb_zif_cap_ctrl.sv
`timescale 1ns/1ps
// Bench for zif_cap_ctrl: directed scenarios plus random captures, each cycle compared
// against a queue-based reference model of the capture rules.
module tb_zif_cap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_wr_in;
  logic [1:0]  cfg_addr_in;
  logic [31:0] cfg_wdata_in;
  logic [31:0] sts_out;
  logic        axis_rx_tvalid_in;
  logic [31:0] axis_rx_tdata_in;
  logic        axis_tx_tvalid_out;
  logic [31:0] axis_tx_tdata_out;
  logic        axis_tx_tlast_out;
  logic        axis_tx_tready_in;
  logic        done_intr_out;

  always #5 clk = ~clk;

  zif_cap_ctrl #(.CNT_W(16)) dut (
    .axis_clk           (clk),
    .rst_n              (rst_n),
    .cfg_wr_in          (cfg_wr_in),
    .cfg_addr_in        (cfg_addr_in),
    .cfg_wdata_in       (cfg_wdata_in),
    .sts_out            (sts_out),
    .axis_rx_tvalid_in  (axis_rx_tvalid_in),
    .axis_rx_tdata_in   (axis_rx_tdata_in),
    .axis_tx_tvalid_out (axis_tx_tvalid_out),
    .axis_tx_tdata_out  (axis_tx_tdata_out),
    .axis_tx_tlast_out  (axis_tx_tlast_out),
    .axis_tx_tready_in  (axis_tx_tready_in),
    .done_intr_out      (done_intr_out)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: phase numbers are the externally visible state codes.
  typedef struct {logic [31:0] d; logic l;} beat_t;
  beat_t       slot[$];
  int          m_state, skip_left, cap_a, frame_a, taken, fpos;
  int          r_cap, r_frame, r_skip;
  bit          ovf, dn, pulse, pat_on;
  logic [31:0] pat_v;

  // Observations from the DUT.
  logic [31:0] got_d[$];
  logic        got_l[$];
  int          pulses, tvalid_seen, done_cyc, last_hs_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    slot.delete();
    m_state = 0; skip_left = 0; cap_a = 0; frame_a = 0; taken = 0; fpos = 0;
    r_cap = 0; r_frame = 0; r_skip = 0;
    ovf = 0; dn = 0; pulse = 0; pat_on = 0; pat_v = 0;
  endtask

  task automatic model_finish();
    m_state = 4; dn = 1; pulse = 1;
  endtask

  task automatic model_update(input bit wr, input logic [1:0] addr, input logic [31:0] wd,
                              input bit rxv, input logic [31:0] rxd, input bit rdy);
    bit    was_full, abort_c, start_c;
    beat_t b;
    was_full = (slot.size() != 0);
    abort_c  = wr && addr == 2'd0 && wd[1];
    start_c  = wr && addr == 2'd0 && wd[0] && !wd[1] && (m_state == 0 || m_state == 4);
    pulse    = 0;
    if (was_full && rdy) void'(slot.pop_front());
    if (wr && addr == 2'd1) r_cap   = int'(wd[15:0]);
    if (wr && addr == 2'd2) r_frame = int'(wd[15:0]);
    if (wr && addr == 2'd3) r_skip  = int'(wd[15:0]);
    if (abort_c) begin
      m_state = 0;
      slot.delete();
    end else if (start_c) begin
      ovf = 0; dn = 0; taken = 0; fpos = 0;
      cap_a = r_cap; frame_a = r_frame; skip_left = r_skip;
      pat_on = wd[2]; pat_v = 0;
      if (r_skip != 0)     m_state = 1;
      else if (r_cap == 0) model_finish();
      else                 m_state = 2;
    end else if (m_state == 1) begin
      if (rxv) begin
        skip_left--;
        if (skip_left == 0) begin
          if (cap_a == 0) model_finish();
          else            m_state = 2;
        end
      end
    end else if (m_state == 2) begin
      if (rxv && slot.size() == 0) begin
`ifdef ZIF_CAP_TEST_PATTERN_EN
        b.d = pat_on ? pat_v : rxd;
`else
        b.d = rxd;
`endif
        pat_v++;
        taken++;
        fpos++;
        b.l = (frame_a != 0 && fpos == frame_a) || (taken == cap_a);
        if (frame_a != 0 && fpos == frame_a) fpos = 0;
        slot.push_back(b);
        if (taken == cap_a) m_state = 3;
      end else if (rxv) begin
        ovf = 1;
      end
    end else if (m_state == 3) begin
      if (!was_full) model_finish();
    end
  endtask

  function automatic logic [31:0] exp_sts();
    return {16'(taken), 11'd0, dn, ovf, 3'(m_state)};
  endfunction

  // One clock: drive at the falling edge, let the rising edge act, compare at the next falling edge.
  task automatic step(input bit wr, input logic [1:0] addr, input logic [31:0] wd,
                      input bit rxv, input logic [31:0] rxd, input bit rdy);
    cfg_wr_in = wr; cfg_addr_in = addr; cfg_wdata_in = wd;
    axis_rx_tvalid_in = rxv; axis_rx_tdata_in = rxd; axis_tx_tready_in = rdy;
    if (axis_tx_tvalid_out && rdy) begin
      got_d.push_back(axis_tx_tdata_out);
      got_l.push_back(axis_tx_tlast_out);
      last_hs_cyc = cyc;
    end
    model_update(wr, addr, wd, rxv, rxd, rdy);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("tvalid", 32'(axis_tx_tvalid_out), 32'(slot.size() != 0));
    if (slot.size() != 0) begin
      check("tdata", axis_tx_tdata_out, slot[0].d);
      check("tlast", 32'(axis_tx_tlast_out), 32'(slot[0].l));
    end
    check("done_intr", 32'(done_intr_out), 32'(pulse));
    check("sts", sts_out, exp_sts());
    if (done_intr_out) pulses++;
    if (axis_tx_tvalid_out) tvalid_seen++;
    if (sts_out[2:0] == 3'd4 && done_cyc < 0) done_cyc = cyc;
  endtask

  task automatic wr_reg(input logic [1:0] addr, input logic [31:0] data);
    step(1'b1, addr, data, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic clear_obs();
    got_d.delete(); got_l.delete();
    pulses = 0; tvalid_seen = 0; done_cyc = -1; last_hs_cyc = -1;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n = 0;
    while (sts_out[2:0] != 3'd4 && n < bound) begin
      step(1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 1'b1);
      n++;
    end
    check(tag, 32'(sts_out[2:0]), 32'd4);
  endtask

  task automatic check_beats(input string tag, input logic [31:0] base, input int n,
                             input int last_mask);
    check({tag, "_count"}, 32'(got_d.size()), 32'(n));
    for (int i = 0; i < n && i < got_d.size(); i++) begin
      check({tag, "_data"}, got_d[i], base + 32'(i));
      check({tag, "_last"}, 32'(got_l[i]), 32'((last_mask >> i) & 1));
    end
  endtask

  initial begin
    int bp_rdy[12] = '{1, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1};
    rst_n = 1'b0;
    cfg_wr_in = 1'b0; cfg_addr_in = 2'd0; cfg_wdata_in = 32'd0;
    axis_rx_tvalid_in = 1'b0; axis_rx_tdata_in = 32'd0; axis_tx_tready_in = 1'b1;
    model_reset();
    clear_obs();
    @(negedge clk);
    check("rst_tvalid", 32'(axis_tx_tvalid_out), 32'd0);
    check("rst_tdata", axis_tx_tdata_out, 32'd0);
    check("rst_tlast", 32'(axis_tx_tlast_out), 32'd0);
    check("rst_intr", 32'(done_intr_out), 32'd0);
    check("rst_sts", sts_out, 32'd0);
    rst_n = 1'b1;
    step(1'b0, 2'd0, 32'd0, 1'b1, 32'h55, 1'b1);

    // Basic capture: skip 2, capture 8 with 4-beat frames.
    wr_reg(2'd1, 32'd8); wr_reg(2'd2, 32'd4); wr_reg(2'd3, 32'd2);
    clear_obs();
    step(1'b1, 2'd0, 32'd1, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 2'd0, 32'd0, 1'b1, 32'(i), 1'b1);
    wait_done("basic_done", 20);
    check_beats("basic", 32'd2, 8, 'h88);
    check("basic_pulses", 32'(pulses), 32'd1);
    check("basic_count", 32'(sts_out[31:16]), 32'd8);

    // Backpressure: downstream stalls for three cycles while rx keeps streaming.
    wr_reg(2'd1, 32'd4); wr_reg(2'd2, 32'd0); wr_reg(2'd3, 32'd0);
    clear_obs();
    step(1'b1, 2'd0, 32'd1, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 2'd0, 32'd0, 1'b1, 32'd100 + 32'(i), 1'(bp_rdy[i]));
    wait_done("bp_done", 20);
    check("bp_count", 32'(got_d.size()), 32'd4);
    if (got_d.size() == 4) begin
      check("bp_d0", got_d[0], 32'd100);
      check("bp_d1", got_d[1], 32'd104);
      check("bp_d3", got_d[3], 32'd106);
      check("bp_last", 32'(got_l[3]), 32'd1);
    end
    check("bp_overflow", 32'(sts_out[3]), 32'd1);
    check("bp_order", 32'(done_cyc > last_hs_cyc), 32'd1);
    check("bp_pulses", 32'(pulses), 32'd1);

    // Zero length.
    wr_reg(2'd1, 32'd0);
    clear_obs();
    step(1'b1, 2'd0, 32'd1, 1'b1, 32'd7, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 32'd0, 1'b1, 32'd8, 1'b1);
    check("zero_state", 32'(sts_out[2:0]), 32'd4);
    check("zero_pulses", 32'(pulses), 32'd1);
    check("zero_tvalid", 32'(tvalid_seen), 32'd0);

    // Abort mid-capture; a CAP_LEN write during capture waits for the next start.
    wr_reg(2'd1, 32'd100);
    clear_obs();
    step(1'b1, 2'd0, 32'd1, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 10; i++)
      step(1'(i == 5), 2'd1, 32'd3, 1'b1, 32'd200 + 32'(i), 1'b1);
    check("abort_pre_count", 32'(sts_out[31:16]), 32'd10);
    step(1'b1, 2'd0, 32'd3, 1'b1, 32'h999, 1'b1);
    check("abort_state", 32'(sts_out[2:0]), 32'd0);
    check("abort_tvalid", 32'(axis_tx_tvalid_out), 32'd0);
    check("abort_pulses", 32'(pulses), 32'd0);
    clear_obs();
    step(1'b1, 2'd0, 32'd1, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 32'd0, 1'b1, 32'd300 + 32'(i), 1'b1);
    wait_done("restart_done", 20);
    check_beats("restart", 32'd300, 3, 'h4);
    check("restart_pulses", 32'(pulses), 32'd1);

    // Reset mid-capture.
    wr_reg(2'd1, 32'd50);
    clear_obs();
    step(1'b1, 2'd0, 32'd1, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 2'd0, 32'd0, 1'b1, 32'd400 + 32'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", 32'(axis_tx_tvalid_out), 32'd0);
    check("mid_rst_tdata", axis_tx_tdata_out, 32'd0);
    check("mid_rst_tlast", 32'(axis_tx_tlast_out), 32'd0);
    check("mid_rst_intr", 32'(done_intr_out), 32'd0);
    check("mid_rst_sts", sts_out, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 32'd0, 1'b1, 32'd450, 1'b1);
    check("post_rst_idle", 32'(sts_out[2:0]), 32'd0);
    wr_reg(2'd1, 32'd2);
    step(1'b1, 2'd0, 32'd1, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 2'd0, 32'd0, 1'b1, 32'd500 + 32'(i), 1'b1);
    wait_done("post_rst_done", 20);
    check_beats("post_rst", 32'd500, 2, 'h2);
    check("post_rst_pulses", 32'(pulses), 32'd1);

    // Test-pattern request.
    wr_reg(2'd1, 32'd3);
    clear_obs();
    step(1'b1, 2'd0, 32'd5, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 32'd0, 1'b1, 32'hA0 + 32'(i), 1'b1);
    wait_done("pat_done", 20);
`ifdef ZIF_CAP_TEST_PATTERN_EN
    check_beats("pat", 32'd0, 3, 'h4);
`else
    check_beats("pat", 32'hA0, 3, 'h4);
`endif

    // Random configurations and traffic.
    for (int it = 0; it < 8; it++) begin
      int n = 0;
      wr_reg(2'd1, 32'($urandom_range(0, 12)));
      wr_reg(2'd2, 32'($urandom_range(0, 4)));
      wr_reg(2'd3, 32'($urandom_range(0, 3)));
      step(1'b1, 2'd0, 32'd1 | (32'($urandom_range(0, 1)) << 2), 1'b0, 32'd0, 1'b1);
      while (sts_out[2:0] != 3'd4 && n < 400) begin
        step(1'b0, 2'd0, 32'd0, 1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)));
        n++;
      end
      check("rand_done", 32'(sts_out[2:0]), 32'd4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zif_cap_ctrl.md
ZIF_CAP_CTRL -- requirements
Module: zif_cap_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the length, skip and capture counters.
REQ-002 axis_clk  in  1: single clock; all logic on rising edge.
REQ-003 rst_n  in  1: reset, asynchronous assert, active-low.
REQ-004 cfg_wr_in  in  1: register write strobe, one cycle per write.
REQ-005 cfg_addr_in  in  2: register select: 0 CTRL, 1 CAP_LEN, 2 FRAME_LEN, 3 SKIP.
REQ-006 cfg_wdata_in  in  32: write data; CAP_LEN, FRAME_LEN and SKIP use bits [CNT_W-1:0].
REQ-007 sts_out  out  32: [2:0] state, [3] overflow, [4] done, [31:16] captured-word count.
REQ-008 axis_rx_tvalid_in  in  1 / axis_rx_tdata_in  in  32: ZIF sample stream; has no backpressure.
REQ-009 axis_tx_tvalid_out  out  1 / axis_tx_tdata_out  out  32 / axis_tx_tlast_out  out  1: captured stream.
REQ-010 axis_tx_tready_in  in  1: downstream ready.
REQ-011 done_intr_out  out  1: one-cycle pulse when a capture completes.

Function
REQ-012 The state machine SHALL have five states, encoded in sts_out[2:0]: IDLE=0, SKIP=1, CAPTURE=2, DRAIN=3, DONE=4.
REQ-013 Writing CTRL bit0=1 (start) in IDLE or DONE SHALL do three things:
- clear overflow, done and the captured-word count;
- load the skip counter;
- go to SKIP, or go straight to CAPTURE if SKIP=0.
- A start in any other state SHALL be ignored.
REQ-014 SKIP SHALL discard rx beats until SKIP valid beats are consumed, then enter CAPTURE on the next cycle.
REQ-015 CAPTURE SHALL forward each rx beat into a one-entry output register, giving 1-cycle latency from rx to tx_tvalid.
REQ-016 The output register SHALL accept a new beat when it is empty, or when tx_tvalid_out and tx_tready_in are both high in the same cycle.
REQ-017 An rx beat arriving while the output register is full and tx_tready_in=0 SHALL be dropped.
- The dropped beat SHALL set sticky overflow.
- The dropped beat SHALL NOT be counted.
REQ-018 tx_tlast_out SHALL be asserted on the beat where either:
- the per-frame count reaches FRAME_LEN, after which the frame count restarts at 0; or
- the beat is the final beat of the capture.
- FRAME_LEN=0 SHALL mean tlast only on the final beat.
REQ-019 When the accepted count reaches CAP_LEN, the block SHALL enter DRAIN and hold there until the output register is empty.
- It SHALL then enter DONE, set sticky done, and pulse done_intr_out for one cycle.
REQ-020 CAP_LEN=0 SHALL go from SKIP or start directly to DONE with one done_intr_out pulse and no tx beats.
REQ-021 Counters SHALL be CNT_W bits with no wrap; the captured count SHALL saturate at 2^CNT_W-1.
REQ-022 Writing CTRL bit1=1 (abort) SHALL move to IDLE on the next cycle from any state.
- Abort SHALL clear axis_tx_tvalid_out.
- Abort SHALL NOT pulse done_intr_out.
- Abort takes precedence over start when both are written together.
REQ-023 Writes to CAP_LEN, FRAME_LEN or SKIP outside IDLE/DONE SHALL be stored but SHALL take effect only at the next start.
REQ-024 tx_tvalid_out SHALL NOT deassert without a handshake, except on abort or reset.

Reset
REQ-025 On rst_n=0, all of the following SHALL be 0: state IDLE, all counters, CAP_LEN, FRAME_LEN, SKIP, sts_out, axis_tx_tvalid_out, axis_tx_tdata_out, axis_tx_tlast_out and done_intr_out.
REQ-026 Reset asserted mid-capture SHALL abandon the capture with no done pulse; after deassertion the block SHALL remain in IDLE until a start is written.

Configuration
REQ-027 With ZIF_CAP_TEST_PATTERN_EN defined, a CTRL bit2=1 at start SHALL replace axis_rx_tdata_in with an internal 32-bit counter.
- The counter starts at 0 at start and increments per accepted rx beat.
- The counter SHALL still be qualified by axis_rx_tvalid_in.
REQ-028 Without ZIF_CAP_TEST_PATTERN_EN, CTRL bit2 SHALL be ignored, no counter logic SHALL be built, and the rx data SHALL always pass through.

Verification
REQ-029 Basic capture: CAP_LEN=8, FRAME_LEN=4, SKIP=2, continuous rx data 0..11, tready=1.
- Required: tx data 2..9, tlast on data 5 and 9, one done pulse, sts_out[31:16]=8.
REQ-030 Backpressure: CAP_LEN=4, tready=0 for 3 cycles while rx is continuous.
- Required: overflow=1, exactly 4 beats delivered, DONE reached only after the last handshake.
REQ-031 Zero length: CAP_LEN=0, start.
- Required: DONE with one done pulse and no tx_tvalid.
REQ-032 Abort: start a capture with CAP_LEN=100, abort after 10 beats.
- Required: IDLE next cycle, tx_tvalid=0, no done pulse; a restart captures normally.
REQ-033 Reset: rst_n low mid-CAPTURE.
- Required: all outputs 0 immediately; after release, a start with CAP_LEN=2 completes normally.
REQ-034 Test pattern: with ZIF_CAP_TEST_PATTERN_EN defined, CTRL=0x5 and CAP_LEN=3.
- Required: tx data 0, 1, 2.
- Without the macro, the same stimulus delivers the rx data.
